// File: rtl/fixed_stack_machine.sv
// Signed fixed-point stack calculator (Qm.Q, N bits) over a circular operand stack.
// Define FIXED_STACK_SATURATE_EN to clamp out-of-range results and track a sticky overflow flag.
module fixed_stack_machine #(
  parameter int N     = 32,
  parameter int Q     = 16,
  parameter int DEPTH = 8,
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_in,
  output logic          ready,
  input  logic [2:0]    opcode,
  input  logic [IW-1:0] idx_a,
  input  logic [IW-1:0] idx_b,
  input  logic [N-1:0]  value,
  output logic [N-1:0]  result,
  output logic          done,
  output logic          err,
  output logic          overflow,
  output logic [IW:0]   count,
  output logic [1:0]    dbg_state
);

`ifdef FIXED_STACK_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [2:0] OP_PUSH  = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_SUB   = 3'd2;
  localparam logic [2:0] OP_MUL   = 3'd3;
  localparam logic [2:0] OP_NEG   = 3'd4;
  localparam logic [2:0] OP_ABS   = 3'd5;
  localparam logic [2:0] OP_CLEAR = 3'd6;
  localparam logic [2:0] OP_OUT   = 3'd7;

  localparam logic [N-1:0]  MINV   = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]  MAXV   = ~MINV;
  localparam logic [IW-1:0] PTR1   = IW'(1);
  localparam logic [IW:0]   CNT1   = (IW+1)'(1);
  localparam logic [IW:0]   FULL   = (IW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_MUL   = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [N-1:0]  mem [DEPTH];
  logic [IW-1:0] wp;
  logic [IW:0]   cnt;
  logic [2:0]    op_q;
  logic [IW-1:0] ia_q, ib_q;
  logic [N-1:0]  val_q, a_q, b_q, res_q;
  logic          bad_q, ovf_q;

  logic [IW-1:0] addr_a, addr_b;
  logic [N-1:0]  opa, opb, res_c, res_fin, mul_fin;
  logic [N:0]    sum, dif;
  logic          need_a, need_b, bad_c, ovf_c, sat_neg_c, push_op;
  logic [2*N-1:0] prod;
  logic [N-Q:0]  mul_hi;
  logic          mul_ovf;
  logic          unused_ok;

  // Handshake: a command transfers on a rising edge where valid_in && ready;
  // ready is high only in S_IDLE and valid_in is ignored otherwise.
  assign ready     = (state == S_IDLE);
  assign done      = (state == S_WRITE) && !reset;
  assign err       = done && bad_q;
  assign result    = res_q;
  assign overflow  = ovf_q;
  assign count     = cnt;
  assign dbg_state = state;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (valid_in) state_nx = S_EXEC;
      S_EXEC:  state_nx = (op_q == OP_MUL) ? S_MUL : S_WRITE;
      S_MUL:   state_nx = S_WRITE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Offset k from the top lives at wp-1-k; IW-bit arithmetic wraps the ring.
  assign addr_a = wp - ia_q - PTR1;
  assign addr_b = wp - ib_q - PTR1;
  assign opa    = mem[addr_a];
  assign opb    = mem[addr_b];

  always_comb begin
    need_a  = (op_q != OP_PUSH) && (op_q != OP_CLEAR);
    need_b  = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_MUL);
    bad_c   = (need_a && ({1'b0, ia_q} >= cnt)) || (need_b && ({1'b0, ib_q} >= cnt));
    push_op = (op_q != OP_CLEAR) && (op_q != OP_OUT);
  end

  always_comb begin
    sum       = {opa[N-1], opa} + {opb[N-1], opb};
    dif       = {opa[N-1], opa} - {opb[N-1], opb};
    res_c     = '0;
    ovf_c     = 1'b0;
    sat_neg_c = 1'b0;
    case (op_q)
      OP_PUSH: res_c = val_q;
      OP_ADD: begin
        res_c     = sum[N-1:0];
        ovf_c     = sum[N] ^ sum[N-1];
        sat_neg_c = sum[N];
      end
      OP_SUB: begin
        res_c     = dif[N-1:0];
        ovf_c     = dif[N] ^ dif[N-1];
        sat_neg_c = dif[N];
      end
      OP_NEG: begin
        res_c = -opa;
        ovf_c = (opa == MINV);
      end
      OP_ABS: begin
        res_c = opa[N-1] ? -opa : opa;
        ovf_c = (opa == MINV);
      end
      OP_OUT:  res_c = opa;
      default: res_c = '0;
    endcase
    res_fin = (SAT && ovf_c) ? (sat_neg_c ? MINV : MAXV) : res_c;
  end

  // Sign-extended unsigned multiply yields the exact low 2N bits of the signed product.
  assign prod      = {{N{a_q[N-1]}}, a_q} * {{N{b_q[N-1]}}, b_q};
  assign mul_hi    = prod[2*N-1:N-1+Q];
  assign mul_ovf   = !((&mul_hi) || !(|mul_hi));
  assign mul_fin   = (SAT && mul_ovf) ? (prod[2*N-1] ? MINV : MAXV) : prod[N-1+Q:Q];
  assign unused_ok = &{1'b0, prod[Q-1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      wp    <= '0;
      cnt   <= '0;
      op_q  <= OP_PUSH;
      ia_q  <= '0;
      ib_q  <= '0;
      val_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      bad_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (valid_in) begin
          op_q  <= opcode;
          ia_q  <= idx_a;
          ib_q  <= idx_b;
          val_q <= value;
        end
        S_EXEC: begin
          bad_q <= bad_c;
          a_q   <= opa;
          b_q   <= opb;
          if (!bad_c && op_q != OP_MUL) begin
            res_q <= res_fin;
            if (SAT && ovf_c) ovf_q <= 1'b1;
          end
        end
        S_MUL: if (!bad_q) begin
          res_q <= mul_fin;
          if (SAT && mul_ovf) ovf_q <= 1'b1;
        end
        default: if (!bad_q) begin
          if (push_op) begin
            wp  <= wp + PTR1;
            cnt <= (cnt == FULL) ? cnt : cnt + CNT1;
          end
          if (op_q == OP_CLEAR) begin
            cnt   <= '0;
            ovf_q <= 1'b0;
          end
        end
      endcase
    end
  end

  // Storage is not reset; entries beyond count are never reachable.
  always_ff @(posedge clk) begin
    if (!reset && state == S_WRITE && !bad_q && push_op)
      mem[wp] <= res_q;
  end

endmodule

// File: tb/tb_fixed_stack_machine.sv
// Directed bench for fixed_stack_machine (N=32, Q=16, DEPTH=8); expectations follow FIXED_STACK_SATURATE_EN.
module tb_fixed_stack_machine;
  localparam int N = 32;
  localparam int Q = 16;
  localparam int DEPTH = 8;
  localparam int IW = 3;

`ifdef FIXED_STACK_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          valid_in = 1'b0;
  logic          ready;
  logic [2:0]    opcode = 3'd0;
  logic [IW-1:0] idx_a = '0;
  logic [IW-1:0] idx_b = '0;
  logic [N-1:0]  value = '0;
  logic [N-1:0]  result;
  logic          done, err, overflow;
  logic [IW:0]   count;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad = 0;
  logic [N-1:0] exp_q[$];

  fixed_stack_machine #(.N(N), .Q(Q), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready(ready),
    .opcode(opcode), .idx_a(idx_a), .idx_b(idx_b), .value(value),
    .result(result), .done(done), .err(err), .overflow(overflow),
    .count(count), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // driver: issue one command, then score result/err/latency/count/ready
  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [IW-1:0] ia,
                         input logic [IW-1:0] ib, input logic [N-1:0] v,
                         input logic [N-1:0] e_res, input logic e_err, input int e_lat,
                         input int e_cnt);
    int w;
    int lat;
    w = 0;
    @(negedge clk);
    while (!ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!ready) begin
      check({tag, "_ready_timeout"}, 0, 1);
      return;
    end
    exp_q.push_back(e_res);
    valid_in = 1'b1;
    opcode = op;
    idx_a = ia;
    idx_b = ib;
    value = v;
    @(negedge clk);
    valid_in = 1'b0;
    opcode = $urandom_range(7, 0);
    value = $urandom;
    lat = 1;
    while (!done && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      check({tag, "_done_timeout"}, 0, 1);
      void'(exp_q.pop_front());
      return;
    end
    check({tag, "_lat"}, lat, e_lat);
    check({tag, "_res"}, result, exp_q.pop_front());
    check({tag, "_err"}, err, e_err);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_ready"}, ready, 1);
    check({tag, "_cnt"}, count, e_cnt);
  endtask

  initial begin : main
    bit seen;
    do_reset();
    check("rst_result", result, 0);
    check("rst_count", count, 0);
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ovf", overflow, 0);

    run_cmd("push_a", 3'd0, 0, 0, 32'h0001_8000, 32'h0001_8000, 0, 2, 1);
    run_cmd("push_b", 3'd0, 0, 0, 32'h0002_4000, 32'h0002_4000, 0, 2, 2);
    run_cmd("add", 3'd1, 0, 1, 0, 32'h0003_C000, 0, 2, 3);
    run_cmd("add_badidx", 3'd1, 0, 5, 0, 32'h0003_C000, 1, 2, 3);
    run_cmd("clear1", 3'd6, 0, 0, 0, 32'h0, 0, 2, 0);

    run_cmd("m_push_a", 3'd0, 0, 0, 32'h0001_8000, 32'h0001_8000, 0, 2, 1);
    run_cmd("m_push_b", 3'd0, 0, 0, 32'h0002_4000, 32'h0002_4000, 0, 2, 2);
    run_cmd("mul", 3'd3, 0, 1, 0, 32'h0003_6000, 0, 3, 3);
    run_cmd("clear2", 3'd6, 0, 0, 0, 32'h0, 0, 2, 0);

    run_cmd("s_push_a", 3'd0, 0, 0, 32'h0001_8000, 32'h0001_8000, 0, 2, 1);
    run_cmd("s_push_b", 3'd0, 0, 0, 32'h0002_4000, 32'h0002_4000, 0, 2, 2);
    run_cmd("sub", 3'd2, 1, 0, 0, 32'hFFFF_4000, 0, 2, 3);
    run_cmd("neg", 3'd4, 0, 7, 0, 32'h0000_C000, 0, 2, 4);
    run_cmd("t_push_a", 3'd0, 0, 0, 32'h0000_0001, 32'h0000_0001, 0, 2, 5);
    run_cmd("t_push_b", 3'd0, 0, 0, 32'hFFFF_8000, 32'hFFFF_8000, 0, 2, 6);
    run_cmd("mul_trunc", 3'd3, 0, 1, 0, 32'hFFFF_FFFF, 0, 3, 7);
    check("ovf_none", overflow, 0);
    run_cmd("clear3", 3'd6, 0, 0, 0, 32'h0, 0, 2, 0);

    run_cmd("o_push_a", 3'd0, 0, 0, 32'h7FFF_0000, 32'h7FFF_0000, 0, 2, 1);
    run_cmd("o_push_b", 3'd0, 0, 0, 32'h7FFF_0000, 32'h7FFF_0000, 0, 2, 2);
    run_cmd("add_ovf", 3'd1, 0, 1, 0, SAT ? 32'h7FFF_FFFF : 32'hFFFE_0000, 0, 2, 3);
    check("ovf_set", overflow, SAT);
    run_cmd("out_top", 3'd7, 1, 0, 0, 32'h7FFF_0000, 0, 2, 3);
    check("ovf_sticky", overflow, SAT);
    run_cmd("clear4", 3'd6, 0, 0, 0, 32'h0, 0, 2, 0);
    check("ovf_cleared", overflow, 0);

    for (int i = 1; i <= 9; i++)
      run_cmd("fill", 3'd0, 0, 0, 32'(i) << Q, 32'(i) << Q, 0, 2, (i > DEPTH) ? DEPTH : i);
    run_cmd("out_oldest", 3'd7, 7, 0, 0, 32'h0002_0000, 0, 2, 8);
    run_cmd("out_newest", 3'd7, 0, 3, 0, 32'h0009_0000, 0, 2, 8);

    do_reset();
    run_cmd("neg_empty", 3'd4, 0, 0, 0, 32'h0, 1, 2, 0);
    run_cmd("a_push", 3'd0, 0, 0, 32'h8000_0000, 32'h8000_0000, 0, 2, 1);
    run_cmd("abs_min", 3'd5, 0, 0, 0, SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 0, 2, 2);
    check("abs_ovf", overflow, SAT);

    // abort a MUL by reset while in the MUL state
    @(negedge clk);
    valid_in = 1'b1;
    opcode = 3'd3;
    idx_a = 0;
    idx_b = 1;
    @(negedge clk);
    valid_in = 1'b0;
    check("abort_exec_state", dbg_state, 1);
    seen = done;
    @(negedge clk);
    check("abort_mul_state", dbg_state, 2);
    seen |= done;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    seen |= done;
    check("abort_ready", ready, 1);
    check("abort_count", count, 0);
    check("abort_result", result, 0);
    check("abort_ovf", overflow, 0);
    repeat (3) begin
      @(negedge clk);
      seen |= done;
    end
    check("abort_no_done", seen, 0);
    run_cmd("post_abort_push", 3'd0, 0, 0, 32'h0000_4000, 32'h0000_4000, 0, 2, 1);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
